// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the parametrised serial sequence detector.
package seq_detect_pkg;

   typedef enum logic {
      MEALY = 1'b0,
      MOORE = 1'b1
   } mode_e;

   localparam int unsigned MASK_W      = 32;
   localparam logic [31:0] DEF_PATTERN = 32'hD;  // "1101", bit 0 = newest
   localparam int unsigned DEF_LEN     = 4;

   // Low n bits set, saturating at MASK_W.
   function automatic logic [MASK_W-1:0] len_mask(input int unsigned n);
      logic [MASK_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MASK_W; i++) begin
         if (i < n) m[i] = 1'b1;
      end
      return m;
   endfunction

   // Force a requested length into 1..max_len.
   function automatic int unsigned clamp_len(input int unsigned l, input int unsigned max_len);
      int unsigned r;
      r = l;
      if (r == 0) r = 1;
      if (r > max_len) r = max_len;
      return r;
   endfunction

endpackage

// File: rtl/seq_window.sv
// History shift register plus valid-bit fill counter with restart after a non-overlapping hit.
module seq_window #(
   parameter  int unsigned MAX_LEN = 8,
   localparam int unsigned LW      = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               shift,
   input  logic               restart,
   input  logic               in,
   input  logic [LW-1:0]      len,
   output logic [MAX_LEN-1:0] hist,
   output logic [LW-1:0]      fill,
   output logic [MAX_LEN-1:0] win_c,
   output logic [LW-1:0]      fill_nx_c
);

   logic [LW:0] fill_inc;

   // Candidate window and saturating fill including the bit currently presented.
   always_comb begin
      win_c     = {hist[MAX_LEN-2:0], in};
      fill_inc  = {1'b0, fill} + (LW+1)'(1);
      fill_nx_c = (fill_inc > {1'b0, len}) ? len : fill_inc[LW-1:0];
   end

   // Shift in accepted bits; config load wipes history.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist <= '0;
         fill <= '0;
      end else if (clr) begin
         hist <= '0;
         fill <= '0;
      end else if (shift) begin
         hist <= win_c;
         fill <= restart ? '0 : fill_nx_c;
      end
   end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial sequence detector with overlap/Mealy-Moore modes and saturating count.
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter  int unsigned        MAX_LEN     = 8,
   parameter  int unsigned        CNT_W       = 8,
   parameter  logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN),
   parameter  int unsigned        RST_LEN     = DEF_LEN,
   localparam int unsigned        LW          = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic               in,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LW-1:0]      cfg_len,
   input  logic               cfg_overlap,
   input  logic               cfg_moore,
   input  logic               cnt_clr,
   output logic               det_out,
   output logic [CNT_W-1:0]   match_cnt,
   output logic [LW-1:0]      fill,
   output logic [MAX_LEN-1:0] hist
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [MAX_LEN-1:0] pat;
   logic [LW-1:0]      len;
   logic               overlap;
   mode_e              mode;
   logic               det_q;

   logic [MAX_LEN-1:0] win_c;
   logic [LW-1:0]      fill_nx_c;
   logic [MAX_LEN-1:0] mask_c;
   logic               accept_c;
   logic               hit_c;
   logic               restart_c;

   seq_window #(
      .MAX_LEN (MAX_LEN)
   ) u_window (
      .clk       (clk),
      .reset     (reset),
      .clr       (cfg_we),
      .shift     (accept_c),
      .restart   (restart_c),
      .in        (in),
      .len       (len),
      .hist      (hist),
      .fill      (fill),
      .win_c     (win_c),
      .fill_nx_c (fill_nx_c)
   );

   // Compare the active-length window against the pattern; a bit arriving with cfg_we is dropped.
   always_comb begin
      mask_c    = MAX_LEN'(len_mask(32'(len)));
      accept_c  = in_valid && !cfg_we;
      hit_c     = accept_c && (fill_nx_c == len) && (((win_c ^ pat) & mask_c) == '0);
      restart_c = hit_c && !overlap;
      det_out   = (mode == MOORE) ? det_q : hit_c;
   end

   // Configuration registers, loaded with clamped length.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat     <= RST_PATTERN;
         len     <= LW'(RST_LEN);
         overlap <= 1'b1;
         mode    <= MEALY;
      end else if (cfg_we) begin
         pat     <= cfg_pattern;
         len     <= LW'(clamp_len(32'(cfg_len), MAX_LEN));
         overlap <= cfg_overlap;
         mode    <= cfg_moore ? MOORE : MEALY;
      end
   end

   // Registered hit for Moore timing; hit is already forced low on a config load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) det_q <= 1'b0;
      else        det_q <= hit_c;
   end

   // Saturating match counter; clear wins over a simultaneous hit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                           match_cnt <= '0;
      else if (cnt_clr)                     match_cnt <= '0;
      else if (hit_c && match_cnt != CNT_MAX) match_cnt <= match_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default (MAX_LEN=8, CNT_W=8) and CNT_W=2 instances share stimulus.
module tb_seq_detect_param;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_bit;
   logic       cfg_we;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       cfg_moore;
   logic       cnt_clr;

   logic       det_out;
   logic [7:0] match_cnt;
   logic [3:0] fill;
   logic [7:0] hist;

   logic       det_out2;
   logic [1:0] match_cnt2;
   logic [3:0] fill2;
   logic [7:0] hist2;

   int checks;
   int failures;

   seq_detect_param dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in          (in_bit),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_moore   (cfg_moore),
      .cnt_clr     (cnt_clr),
      .det_out     (det_out),
      .match_cnt   (match_cnt),
      .fill        (fill),
      .hist        (hist)
   );

   seq_detect_param #(.CNT_W(2)) dut2 (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in          (in_bit),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_moore   (cfg_moore),
      .cnt_clr     (cnt_clr),
      .det_out     (det_out2),
      .match_cnt   (match_cnt2),
      .fill        (fill2),
      .hist        (hist2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load a configuration (and clear the counters) in one cycle.
   task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic mo);
      cfg_we      = 1'b1;
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = ov;
      cfg_moore   = mo;
      cnt_clr     = 1'b1;
      in_valid    = 1'b0;
      tick();
      cfg_we      = 1'b0;
      cnt_clr     = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (det_out !== 1'b0) begin failures++; $display("FAIL reset_det got=%b exp=0", det_out); end
      checks++;
      if (match_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", match_cnt); end
      checks++;
      if (fill !== 4'd0 || hist !== 8'd0) begin
         failures++; $display("FAIL reset_window fill=%0d hist=%h exp 0/00", fill, hist);
      end
   endtask

   task automatic test_mealy_default();
      logic [3:0] bits;
      logic [3:0] exp;
      bits = 4'b1101;
      exp  = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_bit   = bits[3-i];
         #2;
         checks++;
         if (det_out !== exp[3-i]) begin
            failures++; $display("FAIL mealy_det bit%0d got=%b exp=%b", i+1, det_out, exp[3-i]);
         end
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (match_cnt !== 8'd1) begin failures++; $display("FAIL mealy_cnt got=%0d exp=1", match_cnt); end
   endtask

   task automatic test_overlap();
      logic [4:0] bits;
      logic [4:0] exp;
      bits = 5'b10101;
      for (int pass = 0; pass < 2; pass++) begin
         load(8'b101, 4'd3, (pass == 0), 1'b0);
         exp = (pass == 0) ? 5'b00101 : 5'b00100;
         for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_bit   = bits[4-i];
            #2;
            checks++;
            if (det_out !== exp[4-i]) begin
               failures++; $display("FAIL overlap%0d_det bit%0d got=%b exp=%b", 1-pass, i+1, det_out, exp[4-i]);
            end
            tick();
         end
         in_valid = 1'b0;
         checks++;
         if (match_cnt !== ((pass == 0) ? 8'd2 : 8'd1)) begin
            failures++; $display("FAIL overlap%0d_cnt got=%0d exp=%0d", 1-pass, match_cnt, (pass == 0) ? 2 : 1);
         end
      end
   endtask

   task automatic test_moore();
      logic [3:0] bits;
      logic [7:0] vld;
      logic [7:0] gbits;
      load(8'b1101, 4'd4, 1'b1, 1'b1);
      bits = 4'b1101;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_bit   = bits[3-i];
         #2;
         checks++;
         if (det_out !== 1'b0) begin failures++; $display("FAIL moore_early bit%0d got=%b exp=0", i+1, det_out); end
         tick();
      end
      in_valid = 1'b0;
      in_bit   = 1'b0;
      #2;
      checks++;
      if (det_out !== 1'b1) begin failures++; $display("FAIL moore_pulse got=%b exp=1", det_out); end
      tick();
      #2;
      checks++;
      if (det_out !== 1'b0) begin failures++; $display("FAIL moore_width got=%b exp=0", det_out); end
      tick();

      // Accepted bits 1,1,0,1 interleaved with invalid cycles carrying junk.
      load(8'b1101, 4'd4, 1'b1, 1'b1);
      vld   = 8'b10100101;
      gbits = 8'b11110011;
      for (int i = 0; i < 8; i++) begin
         in_valid = vld[7-i];
         in_bit   = gbits[7-i];
         #2;
         checks++;
         if (det_out !== 1'b0) begin failures++; $display("FAIL moore_gap_early cyc%0d got=%b exp=0", i, det_out); end
         tick();
      end
      in_valid = 1'b0;
      #2;
      checks++;
      if (det_out !== 1'b1) begin failures++; $display("FAIL moore_gap_pulse got=%b exp=1", det_out); end
      tick();
      checks++;
      if (match_cnt !== 8'd1) begin failures++; $display("FAIL moore_gap_cnt got=%0d exp=1", match_cnt); end
   endtask

   task automatic test_len_zero();
      logic [3:0] bits;
      load(8'h01, 4'd0, 1'b1, 1'b0);
      bits = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_bit   = bits[3-i];
         #2;
         checks++;
         if (det_out !== bits[3-i]) begin
            failures++; $display("FAIL len0_det bit%0d got=%b exp=%b", i+1, det_out, bits[3-i]);
         end
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (match_cnt !== 8'd3 || fill !== 4'd1) begin
         failures++; $display("FAIL len0_state cnt=%0d fill=%0d exp 3/1", match_cnt, fill);
      end
   endtask

   task automatic test_len_clamp();
      logic [7:0] bits;
      bits = 8'b10110011;
      load(bits, 4'd15, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_bit   = bits[7-i];
         #2;
         checks++;
         if (det_out !== (i == 7)) begin
            failures++; $display("FAIL clamp_det bit%0d got=%b exp=%b", i+1, det_out, (i == 7));
         end
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (fill !== 4'd8 || hist !== bits) begin
         failures++; $display("FAIL clamp_state fill=%0d hist=%h exp 8/%h", fill, hist, bits);
      end
   endtask

   task automatic test_cnt_sat();
      load(8'h01, 4'd1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_bit   = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (match_cnt2 !== 2'd3) begin failures++; $display("FAIL sat_cnt2 got=%0d exp=3", match_cnt2); end
      checks++;
      if (match_cnt !== 8'd5) begin failures++; $display("FAIL sat_cnt8 got=%0d exp=5", match_cnt); end
   endtask

   task automatic test_cfg_collision();
      logic [2:0] bits;
      load(8'b1101, 4'd4, 1'b1, 1'b0);
      bits = 3'b110;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_bit   = bits[2-i];
         tick();
      end
      cfg_we      = 1'b1;
      cfg_pattern = 8'b1101;
      cfg_len     = 4'd4;
      cfg_overlap = 1'b1;
      cfg_moore   = 1'b0;
      in_valid    = 1'b1;
      in_bit      = 1'b1;
      #2;
      checks++;
      if (det_out !== 1'b0) begin failures++; $display("FAIL collide_det got=%b exp=0", det_out); end
      tick();
      cfg_we   = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (hist !== 8'd0 || fill !== 4'd0 || match_cnt !== 8'd0) begin
         failures++; $display("FAIL collide_state hist=%h fill=%0d cnt=%0d exp 00/0/0", hist, fill, match_cnt);
      end
   endtask

   task automatic test_back_to_back_clr();
      logic [6:0] bits;
      logic [6:0] exp;
      load(8'b1101, 4'd4, 1'b1, 1'b0);
      bits = 7'b1101101;
      exp  = 7'b0001001;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_bit   = bits[6-i];
         cnt_clr  = (i == 6);
         #2;
         checks++;
         if (det_out !== exp[6-i]) begin
            failures++; $display("FAIL b2b_det bit%0d got=%b exp=%b", i+1, det_out, exp[6-i]);
         end
         tick();
         if (i == 3) begin
            checks++;
            if (match_cnt !== 8'd1) begin failures++; $display("FAIL b2b_cnt_mid got=%0d exp=1", match_cnt); end
         end
      end
      cnt_clr  = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (match_cnt !== 8'd0) begin failures++; $display("FAIL clr_vs_hit got=%0d exp=0", match_cnt); end
   endtask

   task automatic test_reset_mid();
      logic [2:0] bits;
      logic [2:0] tail;
      load(8'b0110, 4'd4, 1'b0, 1'b0);
      bits = 3'b110;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_bit   = bits[2-i];
         tick();
      end
      in_valid = 1'b0;
      reset    = 1'b0;
      #2;
      checks++;
      if (fill !== 4'd0 || hist !== 8'd0) begin
         failures++; $display("FAIL rstmid_clear fill=%0d hist=%h exp 0/00", fill, hist);
      end
      reset    = 1'b1;
      in_valid = 1'b1;
      in_bit   = 1'b1;
      #1;
      checks++;
      if (det_out !== 1'b0) begin failures++; $display("FAIL rstmid_det got=%b exp=0", det_out); end
      tick();
      checks++;
      if (fill !== 4'd1) begin failures++; $display("FAIL rstmid_fill got=%0d exp=1", fill); end
      // Completing 1,0,1 only hits if the pattern reverted to 1101.
      tail = 3'b101;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_bit   = tail[2-i];
         #2;
         checks++;
         if (det_out !== (i == 2)) begin
            failures++; $display("FAIL rstmid_revert bit%0d got=%b exp=%b", i+2, det_out, (i == 2));
         end
         tick();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      reset       = 1'b0;
      in_valid    = 1'b0;
      in_bit      = 1'b0;
      cfg_we      = 1'b0;
      cfg_pattern = '0;
      cfg_len     = '0;
      cfg_overlap = 1'b0;
      cfg_moore   = 1'b0;
      cnt_clr     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      reset = 1'b1;
      tick();
      test_mealy_default();
      test_overlap();
      test_moore();
      test_len_zero();
      test_len_clamp();
      test_cnt_sat();
      test_cfg_collision();
      test_back_to_back_clr();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
